// File: rtl/op_sequencer.sv
// Handshaked opcode sequencer: accepts an opcode and drives a one-hot select to the
// datapath for a per-opcode number of cycles, then signals done, err or aborted.
module op_sequencer #(
   parameter int                         OPC_W   = 3,
   parameter int                         NUM_OPS = 6,
   parameter int                         LAT_W   = 4,
   parameter logic [NUM_OPS*LAT_W-1:0]   OP_LAT  = 24'h084211
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               op_valid,
   input  logic [OPC_W-1:0]   op_code,
   output logic               op_ready,
   input  logic               abort,
   output logic [NUM_OPS-1:0] sel,
   output logic               start,
   output logic               done,
   output logic               err,
   output logic               aborted,
   output logic [OPC_W-1:0]   last_op,
   output logic               busy
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t             state_reg, state_next;
   logic [LAT_W-1:0]   cnt_reg, cnt_next;
   logic [NUM_OPS-1:0] sel_reg, sel_next;
   logic               start_reg, start_next;
   logic               done_reg, done_next;
   logic               err_reg, err_next;
   logic               aborted_reg, aborted_next;
   logic               busy_reg, busy_next;
   logic               op_ready_reg, op_ready_next;
   logic [OPC_W-1:0]   last_op_reg, last_op_next;

   logic [LAT_W-1:0]   lat_m1 [NUM_OPS];
   logic [NUM_OPS-1:0] onehot;
   logic [LAT_W-1:0]   load;
   logic               accept;

   // Per-op counter reload value (latency minus one, zero latency treated as one)
   // and the one-hot decode of the offered opcode; an out-of-range code decodes to zero.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_OPS; gi++) begin : g_op
         assign lat_m1[gi] = (OP_LAT[gi*LAT_W +: LAT_W] == '0) ? '0
                             : OP_LAT[gi*LAT_W +: LAT_W] - 1'b1;
         assign onehot[gi] = (op_code == OPC_W'(gi));
      end
   endgenerate

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      sel_next     = '0;
      start_next   = 1'b0;
      done_next    = 1'b0;
      err_next     = 1'b0;
      aborted_next = 1'b0;
      busy_next    = 1'b0;
      last_op_next = last_op_reg;
      load         = '0;
      accept       = op_valid && op_ready_reg;
      for (int k = 0; k < NUM_OPS; k++) begin
         if (onehot[k]) load = lat_m1[k];
      end

      case (state_reg)
         IDLE, DONE: begin
            if (accept) begin
               last_op_next = op_code;
               if (|onehot) begin
                  state_next = EXEC;
                  sel_next   = onehot;
                  start_next = 1'b1;
                  busy_next  = 1'b1;
                  cnt_next   = load;
               end else begin
                  state_next = DONE;
                  done_next  = 1'b1;
                  err_next   = 1'b1;
               end
            end else begin
               state_next = IDLE;
            end
         end
         EXEC: begin
            // abort wins over normal completion in the same cycle
            if (abort) begin
               state_next   = DONE;
               done_next    = 1'b1;
               aborted_next = 1'b1;
            end else if (cnt_reg == '0) begin
               state_next = DONE;
               done_next  = 1'b1;
            end else begin
               cnt_next  = cnt_reg - 1'b1;
               sel_next  = sel_reg;
               busy_next = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase

      op_ready_next = (state_next != EXEC);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         sel_reg      <= '0;
         start_reg    <= 1'b0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
         aborted_reg  <= 1'b0;
         busy_reg     <= 1'b0;
         op_ready_reg <= 1'b0;
         last_op_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         sel_reg      <= sel_next;
         start_reg    <= start_next;
         done_reg     <= done_next;
         err_reg      <= err_next;
         aborted_reg  <= aborted_next;
         busy_reg     <= busy_next;
         op_ready_reg <= op_ready_next;
         last_op_reg  <= last_op_next;
      end
   end

   assign sel      = sel_reg;
   assign start    = start_reg;
   assign done     = done_reg;
   assign err      = err_reg;
   assign aborted  = aborted_reg;
   assign busy     = busy_reg;
   assign op_ready = op_ready_reg;
   assign last_op  = last_op_reg;

endmodule

// File: tb/tb_op_sequencer.sv
// Scoreboard bench for op_sequencer: each accepted opcode pushes its expected outcome,
// which is popped and compared when the sequencer reports done.
module tb_op_sequencer;

   logic       clk, rst, op_valid, abort;
   logic [2:0] op_code;
   logic       op_ready, start, done, err, aborted, busy;
   logic [5:0] sel;
   logic [2:0] last_op;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0] code;
      int         sel_len;
      logic       err;
      logic       aborted;
   } exp_t;

   exp_t sb[$];

   localparam int RAW_LAT [8] = '{1, 1, 2, 4, 8, 0, 0, 0};

   op_sequencer dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready),
      .abort(abort), .sel(sel), .start(start), .done(done), .err(err), .aborted(aborted),
      .last_op(last_op), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int eff_lat(input logic [2:0] code);
      return (RAW_LAT[code] == 0) ? 1 : RAW_LAT[code];
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   // Offer an opcode in the current cycle; it is accepted at the next rising edge.
   task automatic offer(input logic [2:0] code, input int abort_at, input bit hold);
      exp_t e;
      checks++;
      if (op_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_before_accept op_ready=%b expected 1", op_ready);
      end
      op_valid  = 1'b1;
      op_code   = code;
      e.code    = code;
      e.err     = (code >= 3'd6);
      e.sel_len = e.err ? 0 : eff_lat(code);
      if (!e.err && abort_at > 0 && abort_at < e.sel_len) e.sel_len = abort_at;
      e.aborted = !e.err && abort_at > 0 && abort_at <= eff_lat(code);
      sb.push_back(e);
      tick();
      if (!hold) op_valid = 1'b0;
   endtask

   // Follow one execution from the cycle after accept up to its done cycle.
   task automatic observe(input int abort_at);
      exp_t       e;
      int         cnt = 0;
      bit         seen = 0;
      logic [5:0] exp_sel;
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL scoreboard_empty size=0 expected >0");
         return;
      end
      exp_sel = (sb[0].code < 3'd6) ? (6'd1 << sb[0].code) : 6'd0;
      for (int i = 1; i <= 40; i++) begin
         if (done === 1'b1) begin
            seen = 1;
            break;
         end
         checks++;
         if (busy !== 1'b1 || op_ready !== 1'b0) begin
            errors++;
            $display("FAIL exec_status cycle=%0d busy=%b op_ready=%b expected 1/0", i, busy, op_ready);
         end
         checks++;
         if (start !== (i == 1)) begin
            errors++;
            $display("FAIL start cycle=%0d start=%b expected %b", i, start, (i == 1));
         end
         checks++;
         if (sel !== exp_sel) begin
            errors++;
            $display("FAIL exec_sel cycle=%0d sel=%b expected %b", i, sel, exp_sel);
         end
         if (sel !== 6'd0) cnt++;
         abort = (i == abort_at);
         tick();
         abort = 1'b0;
      end
      e = sb.pop_front();
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL done_timeout code=%0d done=%b expected 1 within 40 cycles", e.code, done);
         return;
      end
      checks++;
      if (cnt != e.sel_len) begin
         errors++;
         $display("FAIL sel_cycles code=%0d got=%0d expected %0d", e.code, cnt, e.sel_len);
      end
      checks++;
      if (err !== e.err || aborted !== e.aborted) begin
         errors++;
         $display("FAIL done_flags code=%0d err=%b aborted=%b expected %b/%b",
                  e.code, err, aborted, e.err, e.aborted);
      end
      checks++;
      if (last_op !== e.code) begin
         errors++;
         $display("FAIL last_op got=%0d expected %0d", last_op, e.code);
      end
      checks++;
      if (sel !== 6'd0 || busy !== 1'b0 || start !== 1'b0 || op_ready !== 1'b1) begin
         errors++;
         $display("FAIL done_cycle sel=%b busy=%b start=%b op_ready=%b expected 0/0/0/1",
                  sel, busy, start, op_ready);
      end
      $display("op code=%0d sel_cycles=%0d err=%b aborted=%b", e.code, cnt, err, aborted);
   endtask

   task automatic check_idle(input string name);
      checks++;
      if (op_ready !== 1'b1 || done !== 1'b0 || sel !== 6'd0 || busy !== 1'b0 ||
          err !== 1'b0 || aborted !== 1'b0) begin
         errors++;
         $display("FAIL %s op_ready=%b done=%b sel=%b busy=%b err=%b aborted=%b expected idle",
                  name, op_ready, done, sel, busy, err, aborted);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; op_valid = 1'b0; abort = 1'b0; op_code = 3'd0;
      tick(); tick();
      checks++;
      if (op_ready !== 1'b0 || sel !== 6'd0 || start !== 1'b0 || done !== 1'b0 ||
          err !== 1'b0 || aborted !== 1'b0 || busy !== 1'b0 || last_op !== 3'd0) begin
         errors++;
         $display("FAIL reset_state ready=%b sel=%b start=%b done=%b err=%b ab=%b busy=%b last=%0d expected all 0",
                  op_ready, sel, start, done, err, aborted, busy, last_op);
      end
      rst = 1'b0;
      tick();
      check_idle("after_reset");
      $display("reset released op_ready=%b", op_ready);
   endtask

   task automatic test_basic();
      offer(3'd0, 0, 1'b0); observe(0); tick(); check_idle("idle_after_op0");
   endtask

   task automatic test_long_and_zero_lat();
      offer(3'd4, 0, 1'b0); observe(0); tick();
      offer(3'd5, 0, 1'b0); observe(0); tick(); check_idle("idle_after_op5");
   endtask

   task automatic test_invalid();
      offer(3'd6, 0, 1'b0); observe(0); tick();
      offer(3'd7, 0, 1'b0); observe(0); tick(); check_idle("idle_after_invalid");
   endtask

   task automatic test_abort();
      offer(3'd3, 2, 1'b0); observe(2); tick();
      offer(3'd4, 1, 1'b0); observe(1); tick();
      offer(3'd2, 2, 1'b0); observe(2); tick();
      abort = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_idle("abort_in_idle");
      end
      abort = 1'b0;
   endtask

   task automatic test_back_to_back();
      offer(3'd2, 0, 1'b1);
      op_code = 3'd1;
      observe(0);
      offer(3'd1, 0, 1'b0);
      observe(0); tick(); check_idle("idle_after_b2b");
   endtask

   task automatic test_reset_mid_exec();
      offer(3'd4, 0, 1'b0);
      tick();
      checks++;
      if (sel !== 6'b010000 || busy !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_exec sel=%b busy=%b expected 010000/1", sel, busy);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (sel !== 6'd0 || busy !== 1'b0 || done !== 1'b0 || last_op !== 3'd0 || op_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset sel=%b busy=%b done=%b last_op=%0d op_ready=%b expected 0",
                  sel, busy, done, last_op, op_ready);
      end
      sb.delete();
      rst = 1'b0;
      tick();
      check_idle("ready_after_mid_reset");
      offer(3'd3, 0, 1'b0); observe(0); tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_long_and_zero_lat();
      test_invalid();
      test_abort();
      test_back_to_back();
      test_reset_mid_exec();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
